// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction fetch reader:
//   state_e        : fetch FSM states (IDLE / REQ / DRAIN)
//   fetch_entry_t  : one output-buffer entry {data, pc, fault}
//   DEFAULT_ADDR_BASE : reset vector / byte address of instruction word 0
//   FAULT_DATA     : instruction word delivered with a fault entry
//   word_align()   : clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h0000_3000;
  localparam logic [31:0] FAULT_DATA        = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // ready to accept an address from the PC
    REQ   = 2'd1,  // memory read outstanding, response will be buffered
    DRAIN = 2'd2   // memory read outstanding, response will be dropped
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_if
// Bundles the three handshakes around the fetch reader:
//   PC side     : pc_addr, pc_valid -> ; <- pc_ready ; flush ->
//   memory side : <- mem_req, mem_addr ; mem_ack, mem_rdata ->
//   decode side : <- ins_valid, ins_data, ins_pc, ins_fault ; ins_ready ->
// Modports:
//   master : the fetch reader (drives the memory request and decode outputs)
//   slave  : its environment (PC, instruction memory, decode)
// ---------------------------------------------------------------------------
interface ifetch_if;

  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_fault;

  modport master (
    input  pc_addr, pc_valid, flush, mem_ack, mem_rdata, ins_ready,
    output pc_ready, mem_req, mem_addr, ins_valid, ins_data, ins_pc, ins_fault
  );

  modport slave (
    output pc_addr, pc_valid, flush, mem_ack, mem_rdata, ins_ready,
    input  pc_ready, mem_req, mem_addr, ins_valid, ins_data, ins_pc, ins_fault
  );

endinterface

// File: rtl/ifetch_fifo.sv
// ---------------------------------------------------------------------------
// ifetch_fifo
// Small synchronous in-order buffer of fetch entries.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : empty the buffer on this edge (wins over push and pop)
//   push, push_entry : write one entry at the tail
//   pop          : drop the head entry (ignored while empty)
//   head         : current head entry, all-zero while empty
//   count        : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          do_push, do_pop;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    // A push into a full buffer is only legal when the head leaves on the same edge.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the head is forced to zero while empty, so stale words never reach the outputs.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch reader between the PC register and decode. Accepts one
// address at a time from the PC, reads the word from instruction memory over
// a req/ack handshake and hands {word, address, fault} to decode through an
// in-order buffer. Out-of-range addresses produce a fault entry without any
// memory access. flush discards buffered entries and any in-flight response;
// an outstanding memory request is never retracted, its response is drained.
// Ports:
//   clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : ifetch_if.master (PC, memory and decode handshakes)
// Parameters:
//   ADDR_BASE  : byte address of instruction word 0
//   MEM_WORDS  : instruction memory size in 32-bit words
//   FIFO_DEPTH : output buffer entries (power of two, >= 2)
// Build option:
//   IFETCH_ALIGN_CHECK_EN : when defined, a pc_addr with non-zero byte offset
//   is a fault; otherwise the offset is ignored and the word-aligned address
//   is fetched.
// ---------------------------------------------------------------------------
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = DEFAULT_ADDR_BASE,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     Reset_n,
  ifetch_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  // One past the last valid byte; kept in 33 bits so the top of memory cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + (33'(MEM_WORDS) * 33'd4);

  state_e        state_q, state_d;
  logic [31:0]   mem_addr_q, mem_addr_d;

  logic          range_fault;
  logic          align_fault;
  logic          addr_fault;
  logic          pc_ready;
  logic          accept;

  logic          fifo_push;
  fetch_entry_t  fifo_push_entry;
  logic          fifo_pop;
  fetch_entry_t  fifo_head;
  logic [CW-1:0] fifo_count;
  logic          ins_valid;

  assign range_fault = ({1'b0, bus.pc_addr} < {1'b0, ADDR_BASE}) ||
                       ({1'b0, bus.pc_addr} >= ADDR_LIMIT);

`ifdef IFETCH_ALIGN_CHECK_EN
  assign align_fault = (bus.pc_addr[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  assign addr_fault = range_fault || align_fault;

  // Accept only with a free buffer slot: at most one request is outstanding and
  // nothing else pushes while it is, so its response always finds room.
  assign pc_ready = (state_q == IDLE) && !bus.flush && (fifo_count < CW'(FIFO_DEPTH));
  assign accept   = bus.pc_valid && pc_ready;

  always_comb begin
    state_d         = state_q;
    mem_addr_d      = mem_addr_q;
    fifo_push       = 1'b0;
    fifo_push_entry = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (addr_fault) begin
            fifo_push       = 1'b1;
            fifo_push_entry = '{data: FAULT_DATA, pc: bus.pc_addr, fault: 1'b1};
          end else begin
            state_d    = REQ;
            mem_addr_d = word_align(bus.pc_addr);
          end
        end
      end

      REQ: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          // A response landing on the flush edge belongs to the discarded stream.
          if (!bus.flush) begin
            fifo_push       = 1'b1;
            fifo_push_entry = '{data: bus.mem_rdata, pc: mem_addr_q, fault: 1'b0};
          end
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign ins_valid = (fifo_count != '0);
  assign fifo_pop  = ins_valid && bus.ins_ready && !bus.flush;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (Reset_n),
    .clear      (bus.flush),
    .push       (fifo_push),
    .push_entry (fifo_push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // mem_req is decoded from the state register, so it falls with reset
  // asynchronously and has no combinational dependence on mem_ack.
  assign bus.pc_ready  = pc_ready;
  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ins_valid = ins_valid;
  assign bus.ins_data  = fifo_head.data;
  assign bus.ins_pc    = fifo_head.pc;
  assign bus.ins_fault = fifo_head.fault;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch reader sitting downstream of the program counter register. Accepts each instruction address the PC presents, issues a word read to instruction memory over a req/ack handshake, and delivers the fetched instruction with its address to decode through a small in-order buffer. Supports pipeline redirect (flush) and flags out-of-range fetches as faults instead of touching memory.

## Interface
- ADDR_BASE, 32'h00003000, byte address of instruction memory word 0 (PC reset vector)
- MEM_WORDS, 1024, instruction memory size in 32-bit words; valid range ADDR_BASE .. ADDR_BASE+4*MEM_WORDS-1
- FIFO_DEPTH, 2, output buffer entries (power of two, ≥2)
- clk  in  1  sole clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- pc_addr  in  32  instruction byte address from PC register
- pc_valid  in  1  pc_addr valid
- pc_ready  out  1  address accepted on the edge where pc_valid && pc_ready; PC may advance
- flush  in  1  redirect: discard buffered and in-flight fetches
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  32  word-aligned byte address of request
- mem_ack  in  1  read done; mem_rdata valid this cycle
- mem_rdata  in  32  instruction word
- ins_valid  out  1  head entry valid
- ins_ready  in  1  decode consumes head
- ins_data  out  32  instruction word (0 on fault)
- ins_pc  out  32  address the word was fetched from
- ins_fault  out  1  fetch fault for this entry

## Operation
- States: IDLE, REQ, DRAIN. Reset → IDLE, FIFO empty.
- pc_ready = (state==IDLE) && !flush && (fifo_count < FIFO_DEPTH). One memory request outstanding at most.
- Accept in IDLE: if address in range → REQ, latch mem_addr = {pc_addr[31:2],2'b00}, mem_req=1. If out of range → push {data 0, pc_addr, fault 1} on the same edge, stay IDLE, no memory access.
- REQ: mem_req high, mem_addr stable until mem_ack. On mem_ack edge: push {mem_rdata, mem_addr, fault 0}, mem_req=0, → IDLE.
- flush (priority over accept, push and pop): FIFO emptied on that edge; IDLE stays IDLE; REQ without mem_ack → DRAIN; REQ with mem_ack same cycle → IDLE, data discarded.
- DRAIN: mem_req stays high (requests are never retracted); on mem_ack drop response, → IDLE. flush during DRAIN has no further effect.
- FIFO: pop on ins_valid && ins_ready; simultaneous push/pop allowed at any occupancy; ins_* reflect head and are stable while ins_valid && !ins_ready. Overflow impossible by pc_ready rule.
- Range check: faults when pc_addr < ADDR_BASE or pc_addr ≥ ADDR_BASE+4*MEM_WORDS (unsigned, computed in 33 bits, no wrap).

## Timing
- Reset values: mem_req 0, mem_addr 0, ins_valid 0, ins_data 0, ins_pc 0, ins_fault 0; pc_ready 1 once Reset_n high (IDLE, empty).
- Reset_n low mid-request: mem_req drops asynchronously, FIFO cleared; instruction memory must tolerate abandoned request.
- mem_req rises the cycle after accept edge; mem_ack may arrive in that same cycle (zero wait).
- Latency accept → ins_valid: 2 cycles with zero-wait memory, 2+W with W wait cycles; fault entry: 1 cycle.
- Throughput: one fetch per 2 cycles at zero wait (pc_ready low in REQ).
- No combinational path from mem_ack or ins_ready to any output.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined: pc_addr[1:0] != 0 is a fault, handled as out-of-range (no memory access, fault entry).
- Undefined: pc_addr[1:0] ignored, address word-aligned, no misalignment fault; ins_pc carries the aligned address.

## Structure
- Package ifetch_pkg: state enum (IDLE/REQ/DRAIN), FIFO entry struct {data[31:0], pc[31:0], fault}, default ADDR_BASE and FAULT_DATA (32'h0) constants.
- Sub-module ifetch_fifo: synchronous FIFO of entries with push, pop, clear (flush), count output.

## Test plan
- Reset, pc_addr=0x3000 valid, zero-wait memory returns 0x20080001 → mem_req one cycle at 0x3000, ins_valid 2 cycles after accept with ins_data 0x20080001, ins_pc 0x3000, fault 0.
- Fetch 0x3004 with 3 wait cycles → mem_req/mem_addr held 4 cycles, pc_ready low throughout, one push.
- pc_addr=0x2FFC and 0x4000 (MEM_WORDS 1024) → no mem_req, entries with fault 1, data 0, 1-cycle latency.
- ins_ready low, three in-range fetches → two buffered, pc_ready low with count 2; third accepted only after one pop; order preserved.
- flush while REQ waiting → FIFO empty next cycle, mem_req held until ack, response dropped, pc_ready returns after ack.
- With IFETCH_ALIGN_CHECK_EN, pc_addr=0x3002 → fault entry; without it → fetch at 0x3000, fault 0.
